// File: rtl/aes_pkg.sv
// aes_pkg: shared AES constants, column type and GF(2^8) helpers
package aes_pkg;
  localparam int AES_NB      = 4;
  localparam int AES_STATE_W = 128;
  typedef logic [31:0] col_t;
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction
  function automatic logic [7:0] gf_mul2(input logic [7:0] b);
    return xtime(b);
  endfunction
  function automatic logic [7:0] gf_mul3(input logic [7:0] b);
    return xtime(b) ^ b;
  endfunction
endpackage

// File: rtl/shiftrows_mixcolumns_column.sv
// mixcolumns_column: combinational MixColumns of one 32-bit column (row 0 in the top byte)
module mixcolumns_column
  import aes_pkg::*;
(
  input  col_t col_in,
  output col_t col_out
);
  logic [7:0] a0, a1, a2, a3;
  assign {a0, a1, a2, a3} = col_in;
  assign col_out = {gf_mul2(a0) ^ gf_mul3(a1) ^ a2 ^ a3,
                    a0 ^ gf_mul2(a1) ^ gf_mul3(a2) ^ a3,
                    a0 ^ a1 ^ gf_mul2(a2) ^ gf_mul3(a3),
                    gf_mul3(a0) ^ a1 ^ a2 ^ gf_mul2(a3)};
endmodule

// File: rtl/shiftrows_mixcolumns.sv
// shiftrows_mixcolumns: ShiftRows then column-serial MixColumns; AES_MIXCOL_PARALLEL_EN processes all four columns in one cycle
module shiftrows_mixcolumns
  import aes_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ena,
  input  logic                   last_round,
  input  logic [AES_STATE_W-1:0] state_in,
  output logic [AES_STATE_W-1:0] state_out,
  output logic                   done,
  output logic                   busy
);
  localparam int STATE_W = AES_STATE_W;
  localparam int NB      = AES_NB;
  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
  state_t state_q, state_d;
  logic [1:0] col_q, col_d;
  col_t [NB-1:0] work_q, work_d;
  logic last_q, last_d, done_q, done_d;
  logic [STATE_W-1:0] out_q, out_d;
  function automatic logic [STATE_W-1:0] shift_rows(input logic [STATE_W-1:0] s);
    logic [STATE_W-1:0] o;
    o = '0;
    for (int c = 0; c < NB; c++)
      for (int r = 0; r < 4; r++)
        o[STATE_W-1-8*(4*c+r) -: 8] = s[STATE_W-1-8*(4*((c+r)%4)+r) -: 8];
    return o;
  endfunction
`ifdef AES_MIXCOL_PARALLEL_EN
  col_t [NB-1:0] mc_out;
  for (genvar g = 0; g < NB; g++) begin : g_mc
    mixcolumns_column u_mc (.col_in(work_q[g]), .col_out(mc_out[g]));
  end
`else
  col_t mc_out;
  mixcolumns_column u_mc (.col_in(work_q[~col_q]), .col_out(mc_out));
`endif
  // next-state: accept in IDLE, transform columns in RUN, publish result in FINISH
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    work_d  = work_q;
    last_d  = last_q;
    out_d   = out_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (ena) begin
        work_d  = shift_rows(state_in);
        last_d  = last_round;
        col_d   = '0;
        state_d = RUN;
      end
      RUN: begin
`ifdef AES_MIXCOL_PARALLEL_EN
        for (int i = 0; i < NB; i++) work_d[i] = last_q ? work_q[i] : mc_out[i];
        state_d = FINISH;
`else
        work_d[~col_q] = last_q ? work_q[~col_q] : mc_out;
        col_d   = col_q == 2'd3 ? col_q : col_q + 2'd1;
        state_d = col_q == 2'd3 ? FINISH : RUN;
`endif
      end
      FINISH: begin
        out_d   = work_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state registers with synchronous reset aborting any operation in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      col_q   <= '0;
      work_q  <= '0;
      last_q  <= 1'b0;
      out_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      work_q  <= work_d;
      last_q  <= last_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end
  assign state_out = out_q;
  assign done      = done_q;
  assign busy      = state_q != IDLE;
endmodule
